// File: rtl/t5_dload_if.sv
// t5_dload_if -- data-stage / bus / write-back bundle for t5_dload.
//
// Signals:
//   sena     global enable (0 = the load unit holds all state)
//   dwb_*    data bus: read data, acknowledge, strobe, write flag
//   x*       data-stage access descriptor: lane select, strobe bits
//            (xstb[0] = misaligned), funct3, destination register
//   mdat/mrd/mwre  registered write-back of the load result
//   dstall   combinational pipeline stall
//   dmis/derr      one-cycle misaligned / bus-timeout flags
//
// Handshake: an access is offered while dwb_stb=1 and xstb[0]=0, and it is
// held by the data stage until dwb_ack=1 is seen in the same cycle.
// dstall=1 tells the pipeline the access is still open this cycle.
// mwre, dmis and derr are one-cycle registered pulses.
//
// Modports: slave = the load unit, master = whoever drives the pipeline/bus.
interface t5_dload_if;
  logic        sena;
  logic [31:0] dwb_dti;
  logic        dwb_ack;
  logic        dwb_stb;
  logic        dwb_wre;
  logic [3:0]  xsel;
  logic [1:0]  xstb;
  logic [2:0]  xfn3;
  logic [4:0]  xrd;
  logic [31:0] mdat;
  logic [4:0]  mrd;
  logic        mwre;
  logic        dstall;
  logic        dmis;
  logic        derr;

  modport slave (
    input  sena, dwb_dti, dwb_ack, dwb_stb, dwb_wre, xsel, xstb, xfn3, xrd,
    output mdat, mrd, mwre, dstall, dmis, derr
  );

  modport master (
    output sena, dwb_dti, dwb_ack, dwb_stb, dwb_wre, xsel, xstb, xfn3, xrd,
    input  mdat, mrd, mwre, dstall, dmis, derr
  );
endinterface

// File: rtl/t5_dload.sv
// t5_dload -- data-stage load/store bus sequencer with write-back.
//
// Tracks one outstanding data-bus access, stalls the pipeline until it is
// acknowledged, times it out after TMO cycles, and for loads aligns and
// extends the returned data into a one-cycle register-file write.
//
// Ports:
//   sclk       clock, rising edge
//   srst       asynchronous active-low reset
//   bus        t5_dload_if.slave (enable, bus, data-stage, write-back)
//   dbg_state  current FSM state (0 = IDLE, 1 = WAIT)
module t5_dload #(
  parameter int unsigned TMO = 255
) (
  input  logic           sclk,
  input  logic           srst,
  t5_dload_if.slave      bus,
  output logic           dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] mdat_q;
  logic [4:0]  mrd_q;
  logic        mwre_q;
  logic        dmis_q;
  logic        derr_q;

  logic        acc_valid;
  logic        acc_mis;
  logic        tmo_hit;
  logic [31:0] lane;
  logic [31:0] ld_data;

  assign acc_valid = bus.dwb_stb & ~bus.xstb[0];
  assign acc_mis   = bus.dwb_stb &  bus.xstb[0];

  // Last permitted wait cycle passed without an ack; an ack in this same
  // cycle still wins and completes the access.
  assign tmo_hit = (state == WAIT) & acc_valid & ~bus.dwb_ack &
                   (cnt == 8'(TMO - 1));

  // Stall is dropped on the timeout cycle so the pipeline moves on, and is
  // held low throughout reset.
  assign bus.dstall = srst & acc_valid & ~bus.dwb_ack & ~tmo_hit;

  // Lane extraction: move the selected byte/half down to bit 0.
  always_comb begin
    lane = bus.dwb_dti;
    case (bus.xsel)
      4'b0001: lane = {24'd0, bus.dwb_dti[7:0]};
      4'b0010: lane = {24'd0, bus.dwb_dti[15:8]};
      4'b0100: lane = {24'd0, bus.dwb_dti[23:16]};
      4'b1000: lane = {24'd0, bus.dwb_dti[31:24]};
      4'b0011: lane = {16'd0, bus.dwb_dti[15:0]};
      4'b1100: lane = {16'd0, bus.dwb_dti[31:16]};
      default: lane = bus.dwb_dti;
    endcase
  end

  // Extension by access size; xfn3[2] selects zero extension.
  always_comb begin
    ld_data = lane;
    case (bus.xfn3[1:0])
      2'b00:   ld_data = bus.xfn3[2] ? {24'd0, lane[7:0]}
                                     : {{24{lane[7]}}, lane[7:0]};
      2'b01:   ld_data = bus.xfn3[2] ? {16'd0, lane[15:0]}
                                     : {{16{lane[15]}}, lane[15:0]};
      default: ld_data = lane;
    endcase
  end

  always_ff @(posedge sclk or negedge srst) begin
    if (!srst) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      mdat_q <= 32'd0;
      mrd_q  <= 5'd0;
      mwre_q <= 1'b0;
      dmis_q <= 1'b0;
      derr_q <= 1'b0;
    end else if (bus.sena) begin
      mwre_q <= 1'b0;
      dmis_q <= 1'b0;
      derr_q <= 1'b0;
      case (state)
        IDLE: begin
          if (acc_mis) begin
            dmis_q <= 1'b1;
          end else if (acc_valid) begin
            if (bus.dwb_ack) begin
              if (!bus.dwb_wre) begin
                mdat_q <= ld_data;
                mrd_q  <= bus.xrd;
                mwre_q <= 1'b1;
              end
            end else begin
              state <= WAIT;
              cnt   <= 8'd0;
            end
          end
        end
        WAIT: begin
          if (!bus.dwb_stb) begin
            // Data stage withdrew the access: drop it without any flag.
            state <= IDLE;
            cnt   <= 8'd0;
          end else if (acc_mis) begin
            dmis_q <= 1'b1;
            state  <= IDLE;
            cnt    <= 8'd0;
          end else if (bus.dwb_ack) begin
            if (!bus.dwb_wre) begin
              mdat_q <= ld_data;
              mrd_q  <= bus.xrd;
              mwre_q <= 1'b1;
            end
            state <= IDLE;
            cnt   <= 8'd0;
          end else if (tmo_hit) begin
            derr_q <= 1'b1;
            state  <= IDLE;
            cnt    <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

  assign bus.mdat  = mdat_q;
  assign bus.mrd   = mrd_q;
  assign bus.mwre  = mwre_q;
  assign bus.dmis  = dmis_q;
  assign bus.derr  = derr_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_t5_dload.sv
module tb_t5_dload;

  localparam int TMO_B = 4;

  logic sclk;
  logic srst;
  logic dbg_state;

  t5_dload_if bus();

  t5_dload #(.TMO(TMO_B)) dut (
    .sclk      (sclk),
    .srst      (srst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // ---------------- scoreboard ----------------
  // Expected item: {kind[1:0], mrd[4:0], mdat[31:0]}; kind 1=load, 2=mis, 3=err
  logic [38:0] exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: shift the lowest selected byte lane down, then apply the
  // size/sign rule with plain integer arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] dti,
                                           input logic [3:0] sel,
                                           input logic [2:0] fn3);
    int off;
    longint v;
    longint r;
    off = 0;
    for (int i = 3; i >= 0; i--) if (sel[i]) off = i;
    v = longint'(dti) >> (8 * off);
    if (fn3[1:0] == 2'b00) begin
      r = v % 256;
      if (!fn3[2] && r >= 128) r = r - 256;
    end else if (fn3[1:0] == 2'b01) begin
      r = v % 65536;
      if (!fn3[2] && r >= 32768) r = r - 65536;
    end else begin
      r = v;
    end
    return r[31:0];
  endfunction

  // ---------------- monitor ----------------
  always @(negedge sclk) begin
    if (srst && (bus.mwre || bus.dmis || bus.derr)) begin
      int hot;
      logic [38:0] act;
      logic [38:0] exp;
      hot = int'(bus.mwre) + int'(bus.dmis) + int'(bus.derr);
      chk("pulse_exclusive", 64'(hot), 64'd1);
      if (bus.mwre)      act = {2'd1, bus.mrd, bus.mdat};
      else if (bus.dmis) act = {2'd2, 5'd0, 32'd0};
      else               act = {2'd3, 5'd0, 32'd0};
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output actual=0x%0h required=none at %0t", act, $time);
      end else begin
        exp = exp_q.pop_front();
        chk("response", 64'(act), 64'(exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.dwb_stb = 1'b0;
    bus.dwb_ack = 1'b0;
    bus.dwb_wre = 1'b0;
    bus.xstb    = 2'b00;
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that ends the
  // access. w = number of cycles without ack before the ack cycle.
  task automatic do_access(input logic [31:0] dti, input logic [3:0] sel,
                           input logic [2:0] fn3, input logic [4:0] rd,
                           input logic wre, input logic mis, input int w);
    int n;
    int stalls;
    bus.dwb_dti = dti;
    bus.xsel    = sel;
    bus.xfn3    = fn3;
    bus.xrd     = rd;
    bus.dwb_wre = wre;
    bus.xstb    = {1'b0, mis};
    bus.dwb_stb = 1'b1;
    stalls = 0;
    if (mis) begin
      exp_q.push_back({2'd2, 5'd0, 32'd0});
      bus.dwb_ack = 1'($urandom_range(0, 1));
      @(negedge sclk);
      chk("mis_dstall", 64'(bus.dstall), 64'd0);
      @(posedge sclk); #1;
    end else begin
      n = (w > TMO_B) ? TMO_B : w;
      if (w > TMO_B)  exp_q.push_back({2'd3, 5'd0, 32'd0});
      else if (!wre)  exp_q.push_back({2'd1, rd, ref_load(dti, sel, fn3)});
      for (int c = 0; c <= n; c++) begin
        bus.dwb_ack = (c == w);
        @(negedge sclk);
        if (bus.dstall) stalls++;
        @(posedge sclk); #1;
      end
      chk("stall_cycles", 64'(stalls), 64'(n));
    end
    clear_inputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.dwb_ack = 1'($urandom_range(0, 1));  // stray acks must be ignored
      @(posedge sclk); #1;
    end
    bus.dwb_ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] sel;
    logic [2:0] fn3;
    int sz;
    int w;
    srst        = 1'b0;
    bus.sena    = 1'b1;
    bus.dwb_dti = 32'd0;
    bus.xsel    = 4'd0;
    bus.xfn3    = 3'd0;
    bus.xrd     = 5'd0;
    clear_inputs();

    #12;
    chk("rst_mdat",   64'(bus.mdat),   64'd0);
    chk("rst_mrd",    64'(bus.mrd),    64'd0);
    chk("rst_mwre",   64'(bus.mwre),   64'd0);
    chk("rst_dmis",   64'(bus.dmis),   64'd0);
    chk("rst_derr",   64'(bus.derr),   64'd0);
    chk("rst_dstall", 64'(bus.dstall), 64'd0);
    chk("rst_state",  64'(dbg_state),  64'd0);
    @(negedge sclk); srst = 1'b1;
    @(posedge sclk); #1;

    // LB lane 2, zero wait
    do_access(32'h00A50000, 4'b0100, 3'b000, 5'd7, 1'b0, 1'b0, 0);
    chk("lb_mwre", 64'(bus.mwre), 64'd1);
    chk("lb_mdat", 64'(bus.mdat), 64'hFFFFFFA5);
    chk("lb_mrd",  64'(bus.mrd),  64'd7);
    idle(1);
    // LHU upper half, 3 wait cycles
    do_access(32'h80011234, 4'b1100, 3'b101, 5'd9, 1'b0, 1'b0, 3);
    chk("lhu_mdat", 64'(bus.mdat), 64'h00008001);
    idle(1);
    // SW, 1 wait cycle, no write-back
    do_access(32'hDEADBEEF, 4'b1111, 3'b010, 5'd3, 1'b1, 1'b0, 1);
    chk("sw_mwre", 64'(bus.mwre), 64'd0);
    idle(1);
    // misaligned LW
    do_access(32'h12345678, 4'b1111, 3'b010, 5'd4, 1'b0, 1'b1, 0);
    chk("mis_dmis",  64'(bus.dmis),  64'd1);
    chk("mis_mwre",  64'(bus.mwre),  64'd0);
    chk("mis_state", 64'(dbg_state), 64'd0);
    idle(1);
    // LW timeout
    do_access(32'h11112222, 4'b1111, 3'b010, 5'd5, 1'b0, 1'b0, 10);
    chk("tmo_derr",  64'(bus.derr),  64'd1);
    chk("tmo_state", 64'(dbg_state), 64'd0);
    do_access(32'hCAFEF00D, 4'b1111, 3'b010, 5'd6, 1'b0, 1'b0, 0);
    chk("after_tmo_mdat", 64'(bus.mdat), 64'hCAFEF00D);
    idle(1);

    // global enable low: an acked load must not complete
    bus.sena    = 1'b0;
    bus.dwb_dti = 32'h0BADF00D;
    bus.xsel    = 4'b1111;
    bus.xfn3    = 3'b010;
    bus.xrd     = 5'd30;
    bus.dwb_stb = 1'b1;
    bus.dwb_ack = 1'b1;
    repeat (2) begin @(posedge sclk); #1; end
    chk("sena_hold_mdat", 64'(bus.mdat), 64'hCAFEF00D);
    clear_inputs();
    bus.sena = 1'b1;
    idle(1);

    // randomized traffic
    for (int t = 0; t < 150; t++) begin
      sz = $urandom_range(0, 2);
      if (sz == 0)      begin sel = 4'b0001 << $urandom_range(0, 3); fn3 = {1'($urandom_range(0, 1)), 2'b00}; end
      else if (sz == 1) begin sel = ($urandom_range(0, 1) == 1) ? 4'b1100 : 4'b0011; fn3 = {1'($urandom_range(0, 1)), 2'b01}; end
      else              begin sel = 4'b1111; fn3 = 3'b010; end
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO_B, TMO_B + 3) : $urandom_range(0, 3);
      do_access($urandom, sel, fn3, 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0), w);
      idle($urandom_range(0, 2));
    end

    // reset while in WAIT (second wait cycle)
    do_access(32'h0000ABCD, 4'b1111, 3'b010, 5'd12, 1'b0, 1'b0, 0);
    idle(2);
    bus.dwb_dti = 32'h55555555;
    bus.xsel    = 4'b1111;
    bus.xfn3    = 3'b010;
    bus.xrd     = 5'd13;
    bus.dwb_stb = 1'b1;
    bus.dwb_ack = 1'b0;
    @(posedge sclk); #1;
    @(posedge sclk); #1;
    chk("wait_state", 64'(dbg_state), 64'd1);
    #2 srst = 1'b0;
    #1;
    chk("wrst_mdat",   64'(bus.mdat),   64'd0);
    chk("wrst_mrd",    64'(bus.mrd),    64'd0);
    chk("wrst_mwre",   64'(bus.mwre),   64'd0);
    chk("wrst_dstall", 64'(bus.dstall), 64'd0);
    chk("wrst_state",  64'(dbg_state),  64'd0);
    clear_inputs();
    @(negedge sclk); srst = 1'b1;
    @(posedge sclk); #1;
    do_access(32'h76543210, 4'b1111, 3'b010, 5'd14, 1'b0, 1'b0, 0);
    chk("post_rst_mwre", 64'(bus.mwre), 64'd1);
    chk("post_rst_mdat", 64'(bus.mdat), 64'h76543210);
    idle(3);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
